// File: rtl/instruction_loader.sv
// instruction_loader: boot-time writer for the instruction memory.
// Parses a byte stream (length header, big-endian 32-bit words, checksum byte)
// and writes each assembled word to sequential word addresses starting at 0.
// The processor is kept in reset until a complete, checksum-valid image is in.
module instruction_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 1024
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [7:0]            ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  MemWrite,
   output logic [ADDR_WIDTH-1:0] MemAddress,
   output logic [31:0]           MemWriteData,
   output logic                  CpuHold,
   output logic                  Done,
   output logic                  Error,
   output logic [15:0]           WordCount
);

   // Header limit widened once so every length comparison is plain unsigned.
   localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      stIdle,
      stLenHi,
      stLenLo,
      stData,
      stWrite,
      stChk,
      stDone,
      stError
   } loaderState_t;

   loaderState_t state;
   loaderState_t nextState;

   logic [7:0]          lenHi;      // first header byte, held until LEN_LO
   logic [31:0]         wordShift;  // word being assembled, MSB first
   logic [7:0]          sum;        // running mod-256 sum of data bytes
   logic [ADDR_WIDTH:0] wordIndex;  // one extra bit so N = 2^ADDR_WIDTH fits
   logic [1:0]          byteCount;  // byte position inside the current word
   logic [15:0]         wordCountQ;

   logic                byteAccept;
   logic                restart;
   logic [15:0]         headerLen;
   logic [ADDR_WIDTH:0] nextIndex;

   assign byteAccept = ByteValid & ByteReady;
   assign headerLen  = {lenHi, ByteIn};
   assign nextIndex  = wordIndex + 1'b1;

   // Start only matters in the resting states; anywhere else it is ignored.
   assign restart = Start & ((state == stIdle) | (state == stDone) | (state == stError));

   // State register; reset aborts any load in progress on the same edge.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= stIdle;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode from the current state and the accepted byte.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
      nextState = state;
      unique case (state)
         stIdle: begin
            if (Start) nextState = stLenHi;
         end
         stLenHi: begin
            if (byteAccept) nextState = stLenLo;
         end
         stLenLo: begin
            if (byteAccept) begin
               if (32'(headerLen) > MaxWords) begin
                  nextState = stError;
               end else if (headerLen == 16'd0) begin
                  nextState = stChk;
               end else begin
                  nextState = stData;
               end
            end
         end
         stData: begin
            if (byteAccept && (byteCount == 2'd3)) nextState = stWrite;
         end
         stWrite: begin
            // The write cycle never accepts a byte, so the decision is purely on the index.
            if (32'(nextIndex) == 32'(wordCountQ)) begin
               nextState = stChk;
            end else begin
               nextState = stData;
            end
         end
         stChk: begin
            if (byteAccept) begin
               if (ByteIn == sum) begin
                  nextState = stDone;
               end else begin
                  nextState = stError;
               end
            end
         end
         stDone: begin
            if (Start) nextState = stLenHi;
         end
         stError: begin
            if (Start) nextState = stLenHi;
         end
         default: nextState = stIdle;
      endcase
   end

   // Outputs decoded from registered state only: no input-to-output path.
   always_comb begin
      ByteReady = 1'b0;
      MemWrite  = 1'b0;
      Done      = 1'b0;
      Error     = 1'b0;
      CpuHold   = 1'b1;
      unique case (state)
         stLenHi, stLenLo, stData, stChk: ByteReady = 1'b1;
         stWrite:                         MemWrite  = 1'b1;
         stDone: begin
            Done    = 1'b1;
            CpuHold = 1'b0;
         end
         stError:                         Error     = 1'b1;
         default: ;
      endcase
   end

   // Datapath: header capture, word assembly, checksum and write index.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         lenHi      <= 8'd0;
         wordShift  <= 32'd0;
         sum        <= 8'd0;
         wordIndex  <= '0;
         byteCount  <= 2'd0;
         wordCountQ <= 16'd0;
      end else begin
         if (restart) begin
            wordIndex <= '0;
            sum       <= 8'd0;
            byteCount <= 2'd0;
         end
         unique case (state)
            stLenHi: begin
               if (byteAccept) lenHi <= ByteIn;
            end
            stLenLo: begin
               if (byteAccept) wordCountQ <= headerLen;
            end
            stData: begin
               if (byteAccept) begin
                  wordShift <= {wordShift[23:0], ByteIn};
                  sum       <= sum + ByteIn;
                  byteCount <= byteCount + 2'd1;
               end
            end
            stWrite: begin
               wordIndex <= nextIndex;
            end
            default: ;
         endcase
      end
   end

   assign MemAddress   = wordIndex[ADDR_WIDTH-1:0];
   assign MemWriteData = wordShift;
   assign WordCount    = wordCountQ;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: good image, bad checksum, empty
// image, oversize header, gapped stream with stray Start, mid-load reset.
module tb_instruction_loader;

   localparam int AW = 10;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          Start = 1'b0;
   logic [7:0]    ByteIn = 8'd0;
   logic          ByteValid = 1'b0;
   logic          ByteReady;
   logic          MemWrite;
   logic [AW-1:0] MemAddress;
   logic [31:0]   MemWriteData;
   logic          CpuHold;
   logic          Done;
   logic          Error;
   logic [15:0]   WordCount;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int            wrCount = 0;
   logic [AW-1:0] wrAddr [64];
   logic [31:0]   wrData [64];
   int            wrCyc  [64];

   instruction_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(1024)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Start        (Start),
      .ByteIn       (ByteIn),
      .ByteValid    (ByteValid),
      .ByteReady    (ByteReady),
      .MemWrite     (MemWrite),
      .MemAddress   (MemAddress),
      .MemWriteData (MemWriteData),
      .CpuHold      (CpuHold),
      .Done         (Done),
      .Error        (Error),
      .WordCount    (WordCount)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Log every write strobe, sampled mid-cycle.
   always @(negedge Clk) begin
      if (MemWrite === 1'b1) begin
         if (wrCount < 64) begin
            wrAddr[wrCount] = MemAddress;
            wrData[wrCount] = MemWriteData;
            wrCyc[wrCount]  = cyc;
         end
         wrCount++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic startLoad();
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   // Present one byte after an idle gap and return at the negedge after acceptance.
   task automatic sendByte(input logic [7:0] b, input int gap);
      int waitCyc;
      if (gap > 0) begin
         ByteValid = 1'b0;
         repeat (gap) @(negedge Clk);
      end
      ByteIn    = b;
      ByteValid = 1'b1;
      waitCyc   = 0;
      while (ByteReady !== 1'b1 && waitCyc < 50) begin
         @(negedge Clk);
         waitCyc++;
      end
      if (ByteReady !== 1'b1) check("readyTimeout", ByteReady, 1);
      @(negedge Clk);
   endtask

   task automatic sendStream(input logic [7:0] bytes[$], input int maxGap);
      foreach (bytes[i]) begin
         sendByte(bytes[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
      end
      ByteValid = 1'b0;
   endtask

   task automatic checkResetValues(input string pfx);
      check({pfx, "CpuHold"},   CpuHold,      1);
      check({pfx, "ByteReady"}, ByteReady,    0);
      check({pfx, "MemWrite"},  MemWrite,     0);
      check({pfx, "Done"},      Done,         0);
      check({pfx, "Error"},     Error,        0);
      check({pfx, "MemAddr"},   MemAddress,   0);
      check({pfx, "MemData"},   MemWriteData, 0);
      check({pfx, "WordCount"}, WordCount,    0);
   endtask

   task automatic checkGoodImage(input string pfx, input int base);
      check({pfx, "WrCount"}, wrCount - base, 2);
      check({pfx, "Addr0"},   wrAddr[base],       0);
      check({pfx, "Data0"},   wrData[base],       32'h2008_0005);
      check({pfx, "Addr1"},   wrAddr[base + 1],   1);
      check({pfx, "Data1"},   wrData[base + 1],   32'h0109_5020);
      check({pfx, "Done"},    Done,      1);
      check({pfx, "CpuHold"}, CpuHold,   0);
      check({pfx, "Error"},   Error,     0);
      check({pfx, "WordCnt"}, WordCount, 2);
   endtask

   initial begin
      logic [7:0] good[$];
      logic [7:0] badChk[$];
      logic [7:0] empty[$];
      logic [7:0] oversize[$];
      logic [7:0] partA[$];
      logic [7:0] partB[$];
      logic [7:0] maxHdr[$];
      logic [7:0] threeData[$];
      int s;
      int base;

      // 0x20+0x08+0x00+0x05+0x01+0x09+0x50+0x20 = 0xA7
      good      = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'hA7};
      badChk    = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'hA6};
      empty     = '{8'h00, 8'h00, 8'h00};
      oversize  = '{8'h04, 8'h01};
      partA     = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01};
      partB     = '{8'h09, 8'h50, 8'h20, 8'hA7};
      maxHdr    = '{8'h04, 8'h00};
      threeData = '{8'h20, 8'h08, 8'h00};

      // Power-on reset.
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      checkResetValues("por");
      Reset = 1'b1;
      @(negedge Clk);
      check("idleHold",  CpuHold,   1);
      check("idleReady", ByteReady, 0);

      // Good image, ByteValid tied high: latency and throughput.
      base = wrCount;
      startLoad();
      s = cyc;
      check("lenHiReady", ByteReady, 1);
      sendStream(good, 0);
      check("s1Cycles", cyc - s, 13);
      checkGoodImage("s1", base);
      check("s1WrCyc0", wrCyc[base] - s,     6);
      check("s1WrCyc1", wrCyc[base + 1] - s, 11);

      // Bad checksum: words still written, load rejected.
      base = wrCount;
      startLoad();
      sendStream(badChk, 0);
      check("s2WrCount", wrCount - base, 2);
      check("s2Data1",   wrData[base + 1], 32'h0109_5020);
      check("s2Error",   Error,   1);
      check("s2Done",    Done,    0);
      check("s2CpuHold", CpuHold, 1);
      startLoad();
      check("s2RestartReady", ByteReady, 1);
      check("s2RestartError", Error,     0);

      // Empty image from the restarted load.
      base = wrCount;
      sendStream(empty, 0);
      check("s3WrCount", wrCount - base, 0);
      check("s3Done",    Done,      1);
      check("s3CpuHold", CpuHold,   0);
      check("s3WordCnt", WordCount, 0);

      // Oversize header: error right after LEN_LO, no further acceptance.
      base = wrCount;
      startLoad();
      check("s4HoldOnStart", CpuHold, 1);
      sendStream(oversize, 0);
      check("s4Error",   Error,     1);
      check("s4Ready",   ByteReady, 0);
      ByteIn    = 8'h55;
      ByteValid = 1'b1;
      repeat (3) @(negedge Clk);
      ByteValid = 1'b0;
      check("s4ReadyLater", ByteReady, 0);
      check("s4ErrorLater", Error,     1);
      check("s4WordCnt",    WordCount, 16'h0401);
      check("s4WrCount",    wrCount - base, 0);

      // Gapped stream with a stray Start in the middle of the second word.
      base = wrCount;
      startLoad();
      sendStream(partA, 5);
      startLoad();
      check("s5StrayStartReady", ByteReady, 1);
      sendStream(partB, 5);
      repeat (2) @(negedge Clk);
      checkGoodImage("s5", base);

      // Header exactly MAX_WORDS is accepted, then reset after the 5th byte.
      startLoad();
      sendStream(maxHdr, 0);
      check("s6MaxError", Error,     0);
      check("s6MaxReady", ByteReady, 1);
      check("s6MaxCount", WordCount, 16'h0400);
      sendStream(threeData, 0);
      base = wrCount;
      Reset = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      checkResetValues("midRst");
      repeat (8) @(negedge Clk);
      check("midRstNoWrite", wrCount - base, 0);
      check("midRstIdle",    ByteReady, 0);

      // Clean load after the aborted one.
      base = wrCount;
      startLoad();
      sendStream(good, 0);
      checkGoodImage("s7", base);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for the instruction memory that the fetch unit reads. It accepts a byte stream over a valid/ready handshake and parses a length header, big-endian 32-bit instruction words and a trailing checksum byte. Each assembled word is written to sequential instruction-memory word addresses from 0. The processor is held in reset until a complete, checksum-valid image has been loaded.

## Interface
- `ADDR_WIDTH`, default 10: instruction-memory word-address width.
- `MAX_WORDS`, default 1024: largest accepted image in words. Must be ≤ 2^ADDR_WIDTH.
- `Clk`  in  1  rising-edge clock; the only clock.
- `Reset`  in  1  synchronous, active-low reset.
- `Start`  in  1  begins a load. Sampled only in IDLE, DONE and ERROR.
- `ByteIn`  in  8  stream byte.
- `ByteValid`  in  1  `ByteIn` is valid.
- `ByteReady`  out  1  loader can accept a byte this cycle.
- `MemWrite`  out  1  instruction-memory write strobe, one cycle per word.
- `MemAddress`  out  ADDR_WIDTH  word address for the write.
- `MemWriteData`  out  32  instruction word.
- `CpuHold`  out  1  keeps the processor in reset; high until a successful load.
- `Done`  out  1  image loaded and checksum good.
- `Error`  out  1  oversize length or checksum mismatch.
- `WordCount`  out  16  latched header length N.

## Operation
- Stream format: `LEN_HI`, `LEN_LO` (N, big-endian, 16 bits), then 4N data bytes (each word MSB first), then a checksum byte `CHK`.
- `CHK` must equal the mod-256 sum of the 4N data bytes. Header bytes are excluded from the sum.
- A byte is accepted on a rising edge where `ByteValid & ByteReady`.
- States:
  - **IDLE**: `Start` → LEN_HI; clears index, sum, `Done`, `Error`; sets `CpuHold`=1.
  - **LEN_HI**: accept byte → LEN_LO.
  - **LEN_LO**: accept byte, latch N into `WordCount`.
    - N > MAX_WORDS → ERROR.
    - N = 0 → CHK.
    - otherwise → DATA.
  - **DATA**: shift the byte into `MemWriteData` (`{data[23:0], byte}`) and add it to the sum. After the 4th byte of a word → WRITE.
  - **WRITE**: `MemWrite`=1 for exactly one cycle at `MemAddress` = word index, with `ByteReady`=0. Then the index increments.
    - index+1 == N → CHK.
    - otherwise → DATA.
  - **CHK**: accept byte.
    - byte == sum → DONE.
    - otherwise → ERROR.
  - **DONE**: `Done`=1, `CpuHold`=0. `Start` → reload (back to LEN_HI with the IDLE clears).
  - **ERROR**: `Error`=1, `CpuHold`=1. `Start` → reload.
- `ByteReady`=1 only in LEN_HI, LEN_LO, DATA and CHK.
- `Start` is ignored in every other state.
- Words written before a checksum failure remain in memory. `CpuHold` staying high is the only protection against running them.
- Arithmetic:
  - Sum: 8-bit wrap-around.
  - Word index: ADDR_WIDTH+1 bits, so index N = 2^ADDR_WIDTH is representable.
  - N comparison: unsigned 16-bit.

## Timing
- Reset values (Reset low at an edge):
  - state IDLE;
  - `CpuHold`=1;
  - `ByteReady`, `MemWrite`, `Done`, `Error` = 0;
  - `MemAddress`, `MemWriteData`, `WordCount` = 0;
  - sum and index = 0.
- Reset mid-load aborts immediately. No `MemWrite` after the reset edge.
- All outputs are decoded from registered state, so there is no combinational path from inputs to outputs.
- Write latency: 4th byte of a word accepted at edge k → `MemWrite` high during cycle k→k+1, address and data stable for that cycle.
- Peak throughput: 4 bytes per 5 cycles.
- `ByteValid` gaps of any length are legal. State holds while `ByteValid`=0.
- `Done`/`Error` go high the cycle after the deciding byte is accepted.
- `CpuHold` falls on the same edge `Done` rises.
- `Start` held high across DONE restarts only once. It is ignored once the FSM leaves DONE.

## Test plan
- Image N=2, words 0x20080005 and 0x01095020, `CHK`=0xA7, `ByteValid` tied high:
  - exactly two `MemWrite` pulses: addr 0 = 0x20080005, addr 1 = 0x01095020;
  - `Done`=1, `CpuHold`=0, `Error`=0, `WordCount`=2;
  - 2+8+1 bytes accepted in 13 cycles after `Start`.
- Same image with `CHK`=0xA6:
  - both writes occur;
  - `Error`=1, `Done`=0, `CpuHold`=1;
  - `Start` then restarts at LEN_HI.
- Header 0x00 0x00 with `CHK`=0x00 → no `MemWrite`, `Done`=1, `CpuHold`=0.
- MAX_WORDS=1024, header 0x04 0x01:
  - `Error`=1 the cycle after `LEN_LO` is accepted;
  - `ByteReady`=0 thereafter;
  - no writes.
- Good image with random 0–5 cycle `ByteValid` gaps, and `Start` pulsed mid-load → same writes and result as the first scenario; the mid-load `Start` has no effect.
- `Reset` low for one cycle after the 5th byte of a load:
  - all outputs at reset values;
  - no further `MemWrite`;
  - a subsequent `Start` plus a good image loads correctly.
